// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared CPU definitions for the register file and the flags
//                register: default widths, the packed flags type and the bit
//                positions of each flag inside the 4-bit flags word (used by
//                branch decode).
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int C_DEF_DATA_W   = 8;
    localparam int C_DEF_NUM_REGS = 8;

    // Flag bit positions inside the {Z, N, V, C} word, MSB first.
    localparam int C_FLAG_Z_IDX = 3;
    localparam int C_FLAG_N_IDX = 2;
    localparam int C_FLAG_V_IDX = 1;
    localparam int C_FLAG_C_IDX = 0;

    // Field order matches the flags port: z is the MSB, c the LSB.
    typedef struct packed {
        logic z;
        logic n;
        logic v;
        logic c;
    } flags_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_flags_reg.sv
`default_nettype none
// ============================================================================
//  Module      : flags_reg
//  Description : Status-flag register. Latches zero, negative, signed
//                overflow and carry from the ALU result when i_flags_en is
//                high; holds otherwise.
//  Ports       : clk, rst_n       - clock, asynchronous active-low reset
//                i_flags_en       - flag-update strobe
//                i_result         - ALU result (Z/N derived from it)
//                i_carry          - ALU carry flag
//                i_overflow       - ALU signed-overflow flag
//                o_flags          - registered {z, n, v, c}
//  Revision    : 1.0 - initial release
// ============================================================================
module flags_reg
    import reg_file_pkg::*;
#(
    parameter int DATA_W = C_DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flags_en,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_carry,
    input  logic              i_overflow,
    output flags_t            o_flags
);

    flags_t w_next;
    flags_t r_flags;

    // Z/N come from the result regardless of whether it is written back,
    // so compare-style ops and writes to R0 still set them.
    always_comb begin
        w_next   = '0;
        w_next.z = (i_result == '0);
        w_next.n = i_result[DATA_W-1];
        w_next.v = i_overflow;
        w_next.c = i_carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (i_flags_en) begin
            r_flags <= w_next;
        end
    end

    assign o_flags = r_flags;

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : ALU register file with two combinational read ports, one
//                synchronous write port, optional same-cycle write-to-read
//                forwarding and a {Z, N, V, C} flags register. R0 reads as
//                zero and ignores writes. NUM_REGS must be a power of two
//                and at least 2 so every address maps to a register.
//  Ports       : clk, rst_n             - clock, asynchronous active-low reset
//                rd_addr_a / rd_data_a  - read port A (ALU op_a)
//                rd_addr_b / rd_data_b  - read port B (ALU op_b)
//                wr_en, wr_addr, wr_data - write port (ALU result)
//                flags_en               - flag-update strobe
//                carry_in, overflow_in  - ALU carry / signed overflow
//                flags                  - registered {Z, N, V, C}
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter  int DATA_W   = C_DEF_DATA_W,
    parameter  int NUM_REGS = C_DEF_NUM_REGS,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flags_en,
    input  logic              carry_in,
    input  logic              overflow_in,
    output logic [3:0]        flags
);

    logic [DATA_W-1:0] w_regs [NUM_REGS];
    logic              w_wr_ok;
    flags_t            w_flags;

    // A write to R0 is not a write at all: it neither updates storage nor
    // acts as a forwarding source.
    assign w_wr_ok = wr_en && (wr_addr != '0);

    // ------------------------------------------------------------------
    // Storage: entry 0 is a constant, entries 1..NUM_REGS-1 are flops.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_row
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_flop
                logic [DATA_W-1:0] r_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (w_wr_ok && (wr_addr == ADDR_W'(gi))) begin
                        r_q <= wr_data;
                    end
                end

                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports, with optional forwarding of the in-flight write data.
    // ------------------------------------------------------------------
    generate
        if (BYPASS != 0) begin : g_bypass
            assign rd_data_a = (w_wr_ok && (rd_addr_a == wr_addr)) ? wr_data
                                                                    : w_regs[rd_addr_a];
            assign rd_data_b = (w_wr_ok && (rd_addr_b == wr_addr)) ? wr_data
                                                                    : w_regs[rd_addr_b];
        end else begin : g_no_bypass
            assign rd_data_a = w_regs[rd_addr_a];
            assign rd_data_b = w_regs[rd_addr_b];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Flags
    // ------------------------------------------------------------------
    flags_reg #(
        .DATA_W (DATA_W)
    ) u_flags (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flags_en (flags_en),
        .i_result   (wr_data),
        .i_carry    (carry_in),
        .i_overflow (overflow_in),
        .o_flags    (w_flags)
    );

    assign flags = w_flags;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Scoreboard bench for reg_file (BYPASS=1, 8 x 8-bit).
//                Stimulus pushes expected {rd_data_a, rd_data_b, flags} and
//                raises a sample event; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int DW = 8;
    localparam int NR = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          flags_en = 1'b0;
    logic          carry_in = 1'b0;
    logic          overflow_in = 1'b0;
    logic [3:0]    flags;

    always #5 clk = ~clk;

    reg_file #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .BYPASS   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr_a   (rd_addr_a),
        .rd_data_a   (rd_data_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_b   (rd_data_b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .flags_en    (flags_en),
        .carry_in    (carry_in),
        .overflow_in (overflow_in),
        .flags       (flags)
    );

    typedef struct {
        string         name;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    f;
    } exp_t;

    exp_t sb[$];
    event ev_sample;
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: register array and flags, updated on the clock edge.
    logic [DW-1:0] model [NR];
    logic [3:0]    mflags;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) model[i] <= '0;
            mflags <= '0;
        end else begin
            if (wr_en && wr_addr != 0) model[wr_addr] <= wr_data;
            if (flags_en) mflags <= {(wr_data == 0), wr_data[DW-1], overflow_in, carry_in};
        end
    end

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] ad);
        if (ad == 0) return '0;
        if (rst_n && wr_en && wr_addr == ad) return wr_data;
        return model[ad];
    endfunction

    // Monitor: compares whenever the stimulus signals that outputs are valid.
    initial begin
        exp_t e;
        forever begin
            @(ev_sample);
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_empty: sample with no expectation queued");
            end else begin
                e = sb.pop_front();
                if (rd_data_a !== e.a || rd_data_b !== e.b || flags !== e.f) begin
                    n_bad++;
                    $display("FAIL %s: got a=%h b=%h flags=%b, expected a=%h b=%h flags=%b",
                             e.name, rd_data_a, rd_data_b, flags, e.a, e.b, e.f);
                end
            end
        end
    end

    task automatic expect_now(input string nm, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [3:0] f);
        exp_t e;
        e.name = nm;
        e.a    = a;
        e.b    = b;
        e.f    = f;
        sb.push_back(e);
        -> ev_sample;
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic fe, input logic ci, input logic vi,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        wr_en       = we;
        wr_addr     = wa;
        wr_data     = wd;
        flags_en    = fe;
        carry_in    = ci;
        overflow_in = vi;
        rd_addr_a   = ra;
        rd_addr_b   = rb;
    endtask

    // Directed cycle with hand-computed expectations before and after the edge.
    task automatic dcycle(input string nm,
                          input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic fe, input logic ci, input logic vi,
                          input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                          input logic [DW-1:0] pre_a, input logic [DW-1:0] pre_b,
                          input logic [3:0] pre_f,
                          input logic [DW-1:0] post_a, input logic [DW-1:0] post_b,
                          input logic [3:0] post_f);
        @(negedge clk);
        drive(we, wa, wd, fe, ci, vi, ra, rb);
        #1;
        expect_now({nm, "_pre"}, pre_a, pre_b, pre_f);
        @(posedge clk);
        #1;
        expect_now({nm, "_post"}, post_a, post_b, post_f);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          we, fe, ci, vi;
        logic [AW-1:0] wa, ra, rb;
        logic [DW-1:0] wd;

        // Reset from time zero: everything reads zero.
        #2;
        expect_now("reset_init", 8'h00, 8'h00, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        dcycle("wr_r3",   1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3,
               8'hA5, 8'hA5, 4'b0000, 8'hA5, 8'hA5, 4'b0000);
        dcycle("rd_r3",   1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0,
               8'hA5, 8'h00, 4'b0000, 8'hA5, 8'h00, 4'b0000);
        dcycle("wr_r0",   1'b1, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0,
               8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b0000);
        dcycle("cmp_z_c", 1'b0, 3'd3, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 3'd1,
               8'hA5, 8'h00, 4'b0000, 8'hA5, 8'h00, 4'b1001);
        dcycle("flag_nv", 1'b0, 3'd0, 8'h80, 1'b1, 1'b0, 1'b1, 3'd3, 3'd0,
               8'hA5, 8'h00, 4'b1001, 8'hA5, 8'h00, 4'b0110);
        dcycle("flag_hold", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0,
               8'hA5, 8'h00, 4'b0110, 8'hA5, 8'h00, 4'b0110);
        dcycle("wr_and_flags", 1'b1, 3'd5, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd5, 3'd3,
               8'hFF, 8'hA5, 4'b0110, 8'hFF, 8'hA5, 4'b0101);
        dcycle("flags_wa0", 1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 3'd0,
               8'hFF, 8'h00, 4'b0101, 8'hFF, 8'h00, 4'b1000);
        dcycle("b2b_1", 1'b1, 3'd6, 8'h11, 1'b0, 1'b0, 1'b0, 3'd6, 3'd6,
               8'h11, 8'h11, 4'b1000, 8'h11, 8'h11, 4'b1000);
        dcycle("b2b_2", 1'b1, 3'd6, 8'h22, 1'b0, 1'b0, 1'b0, 3'd6, 3'd5,
               8'h22, 8'hFF, 4'b1000, 8'h22, 8'hFF, 4'b1000);
        dcycle("b2b_rd", 1'b0, 3'd6, 8'h33, 1'b0, 1'b0, 1'b0, 3'd6, 3'd3,
               8'h22, 8'hA5, 4'b1000, 8'h22, 8'hA5, 4'b1000);

        // Asynchronous reset mid-cycle with a write pending.
        @(negedge clk);
        drive(1'b1, 3'd2, 8'h3C, 1'b1, 1'b1, 1'b1, 3'd3, 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("async_rst", 8'h00, 8'h00, 4'b0000);
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < NR; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(NR - 1 - i);
            #1;
            expect_now($sformatf("rst_addr%0d", i), 8'h00, 8'h00, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd6;
        #1;
        expect_now("write_lost", 8'h00, 8'h00, 4'b0000);

        // Random sweep against the reference model.
        for (int n = 0; n < 10000; n++) begin
            we = 1'($urandom);
            fe = 1'($urandom);
            ci = 1'($urandom);
            vi = 1'($urandom);
            wa = AW'($urandom);
            wd = DW'($urandom);
            ra = AW'($urandom);
            rb = AW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ra = wa;
                rb = wa;
            end
            if ($urandom_range(0, 7) == 0) wd = '0;
            @(negedge clk);
            drive(we, wa, wd, fe, ci, vi, ra, rb);
            #1;
            expect_now("rand_pre", m_read(rd_addr_a), m_read(rd_addr_b), mflags);
            @(posedge clk);
            #1;
            expect_now("rand_post", m_read(rd_addr_a), m_read(rd_addr_b), mflags);
        end

        @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: %0d expectations not consumed, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file.md
# reg_file

Register file and status-flag register feeding the ALU. Two combinational read ports drive the ALU `op_a`/`op_b` inputs. One synchronous write port captures the ALU result at writeback. A flags register latches zero, negative, signed-overflow and carry from the same result for downstream branch logic.

## Interface
- `DATA_W`, 8: register and ALU data width.
- `NUM_REGS`, 8: number of architectural registers; must be a power of two, ≥2.
- `ADDR_W`, `$clog2(NUM_REGS)`: register address width (derived; do not override).
- `BYPASS`, 1: 1 = write-to-read forwarding in the same cycle; 0 = reads return the old value.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `rd_addr_a`, input, `ADDR_W`: read port A address.
- `rd_data_a`, output, `DATA_W`: read port A data; connects to ALU `op_a`.
- `rd_addr_b`, input, `ADDR_W`: read port B address.
- `rd_data_b`, output, `DATA_W`: read port B data; connects to ALU `op_b`.
- `wr_en`, input, 1: write strobe.
- `wr_addr`, input, `ADDR_W`: write address.
- `wr_data`, input, `DATA_W`: write data; the ALU `out`.
- `flags_en`, input, 1: flag-update strobe.
- `carry_in`, input, 1: ALU `carry_flag`.
- `overflow_in`, input, 1: ALU `signed_overflow`.
- `flags`, output, 4: registered flags `{Z, N, V, C}`, MSB first.

## Operation
- Storage: `NUM_REGS` × `DATA_W` flops; R0 is hardwired zero.
- R0 behaviour:
  - Reads of address 0 always return 0.
  - Writes to address 0 are discarded.
  - R0 is never a bypass source.
- Reads are purely combinational from the address and storage; the block holds no read-side state.
- Write: when `wr_en`=1 at a rising edge, `wr_addr`≠0 ⇒ `regs[wr_addr] <= wr_data`.
- Bypass (`BYPASS`=1): if `wr_en`=1, `wr_addr`≠0 and `rd_addr_x`==`wr_addr`, then `rd_data_x` = `wr_data` combinationally. Ports A and B forward independently; both may forward at once.
- Flags: when `flags_en`=1 at a rising edge, all four flags update together from the current inputs:
  - `Z <= (wr_data == 0)`
  - `N <= wr_data[DATA_W-1]`
  - `V <= overflow_in`
  - `C <= carry_in`
- Flag computation does not depend on `wr_en` or `wr_addr`. A compare-style op (`flags_en`=1, `wr_en`=0) updates flags without writing a register.
- A flag update with `wr_addr`=0 still computes Z/N from `wr_data`.
- `flags_en`=0: flags hold.
- `wr_en` and `flags_en` are independent and may assert in the same cycle.
- There is no handshake. Every strobe is accepted in the cycle it is asserted and the block never stalls.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - All registers and `flags` clear to 0 immediately, without waiting for a clock edge.
  - `rd_data_a`/`rd_data_b` therefore read 0.
  - Writes and flag updates are blocked while `rst_n`=0.
- Reset deassertion: the first rising edge with `rst_n`=1 may perform a write or flag update.
- Reset asserted mid-operation: a pending write in the same cycle is lost, and the register reads 0.
- Read latency: 0 cycles, combinational.
- Write-to-read latency:
  - `BYPASS`=1: 0 cycles.
  - `BYPASS`=0: 1 cycle (value is visible after the edge).
- Flag latency: 1 cycle. `flags` reflects an update on the edge where `flags_en`=1.
- Back-to-back writes to the same address: the last one wins, one per cycle.

## Structure
- Shared CPU package holds:
  - `DATA_W` and `NUM_REGS` defaults.
  - `flags_t` packed struct `{z, n, v, c}`, 4 bits, field order matching the `flags` port.
  - Flag bit-index localparams used by branch decode.
- Natural sub-module: `flags_reg`. It holds the four flag flops, the Z/N derivation and the `flags_en` gating.
- `reg_file` keeps the register array, the R0 masking and the bypass muxes.

## Test plan
- Reset with `rst_n`=0 mid-cycle: `flags`=4'b0000 and both read ports return 0x00 for every address, with no clock edge needed.
- Write 0xA5 to R3, then read A=3, B=3: both return 0xA5. With `BYPASS`=1 and the same-cycle read, `rd_data_a`=0xA5 before the edge.
- Write 0x7F to R0, then read A=0: returns 0x00. With the same-cycle bypass attempt, it still returns 0x00.
- `flags_en`=1, `wr_en`=0, `wr_data`=0x00, `carry_in`=1, `overflow_in`=0: after the edge `flags`=4'b1001 and no register changes.
- `flags_en`=1, `wr_data`=0x80, `overflow_in`=1, `carry_in`=0: `flags`=4'b0110. Next cycle with `flags_en`=0 and new inputs: `flags` holds 4'b0110.
- Random sweep of 10000 cycles against a reference array model: all read data and flags must match, including collisions where `wr_addr`==`rd_addr_a`==`rd_addr_b`.
